// File: rtl/vpu_exec_sequencer.sv
// rtl/vpu_exec_sequencer.sv - operand fetch / execute / writeback sequencer for one VPU op
//
// Purpose: accepts one decoded vector op at a time, issues the source operand
// reads on the SRAM read ports, waits out the read latency, starts the
// execution unit, waits (with timeout) for completion and strobes writeback.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_opcode_i             operation code
//   req_src_cnt_i            number of source operands (0..3)
//   req_src_addr_i           source addresses, port i in slice i
//   req_dst_addr_i           writeback address
//   rd_en_o, rd_addr_o       per-port SRAM read enable / address
//   exec_start_o             one-cycle start pulse to the execution unit
//   exec_opcode_o            opcode held stable for the execution unit
//   exec_done_i              execution unit completion pulse
//   wr_en_o, wr_addr_o       result writeback strobe / address
//   busy_o                   sequencer not idle
//   err_timeout_o            one-cycle pulse on execution timeout
module vpu_exec_sequencer #(
    parameter int SRAM_R_PORT_CNT = 3,
    parameter int ADDR_WIDTH      = 10,
    parameter int OPCODE_WIDTH    = 8,
    parameter int RD_LATENCY      = 2,
    parameter int TIMEOUT         = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [OPCODE_WIDTH-1:0]               req_opcode_i,
    input  logic [1:0]                            req_src_cnt_i,
    input  logic [SRAM_R_PORT_CNT*ADDR_WIDTH-1:0] req_src_addr_i,
    input  logic [ADDR_WIDTH-1:0]                 req_dst_addr_i,
    output logic [SRAM_R_PORT_CNT-1:0]            rd_en_o,
    output logic [SRAM_R_PORT_CNT*ADDR_WIDTH-1:0] rd_addr_o,
    output logic                                  exec_start_o,
    output logic [OPCODE_WIDTH-1:0]               exec_opcode_o,
    input  logic                                  exec_done_i,
    output logic                                  wr_en_o,
    output logic [ADDR_WIDTH-1:0]                 wr_addr_o,
    output logic                                  busy_o,
    output logic                                  err_timeout_o
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_READ       = 3'd1;
    localparam logic [2:0] S_RD_WAIT    = 3'd2;
    localparam logic [2:0] S_EXEC_START = 3'd3;
    localparam logic [2:0] S_EXEC_WAIT  = 3'd4;
    localparam logic [2:0] S_WB         = 3'd5;

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [2:0]                            state_q, state_d;
    logic [2:0]                            rd_cnt_q, rd_cnt_d;
    logic [TO_W-1:0]                       to_cnt_q, to_cnt_d;
    logic                                  err_q, err_d;
    logic [OPCODE_WIDTH-1:0]               opcode_q;
    logic [OPCODE_WIDTH-1:0]               exec_op_q;
    logic [1:0]                            src_cnt_q;
    logic [SRAM_R_PORT_CNT*ADDR_WIDTH-1:0] src_addr_q;
    logic [ADDR_WIDTH-1:0]                 dst_q;
    logic [1:0]                            src_cnt_clamped;
    logic                                  accept;

    assign accept = (state_q == S_IDLE) && req_valid_i;

    assign src_cnt_clamped = (32'(req_src_cnt_i) > SRAM_R_PORT_CNT) ?
                             2'(SRAM_R_PORT_CNT) : req_src_cnt_i;

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        to_cnt_d = to_cnt_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = (src_cnt_clamped == 2'd0) ? S_EXEC_START : S_READ;
                end
            end
            S_READ: begin
                if (RD_LATENCY > 1) begin
                    state_d  = S_RD_WAIT;
                    // Down-counter spans RD_LATENCY-1 wait cycles, ending at zero.
                    rd_cnt_d = 3'(RD_LATENCY - 2);
                end else begin
                    state_d = S_EXEC_START;
                end
            end
            S_RD_WAIT: begin
                if (rd_cnt_q == 3'd0) begin
                    state_d = S_EXEC_START;
                end else begin
                    rd_cnt_d = rd_cnt_q - 3'd1;
                end
            end
            S_EXEC_START: begin
                state_d  = S_EXEC_WAIT;
                to_cnt_d = '0;
            end
            S_EXEC_WAIT: begin
                // Done is checked first so it wins over a coincident timeout.
                if (exec_done_i) begin
                    state_d = S_WB;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_cnt_q   <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            opcode_q   <= '0;
            exec_op_q  <= '0;
            src_cnt_q  <= '0;
            src_addr_q <= '0;
            dst_q      <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
            if (accept) begin
                opcode_q   <= req_opcode_i;
                src_cnt_q  <= src_cnt_clamped;
                src_addr_q <= req_src_addr_i;
                dst_q      <= req_dst_addr_i;
            end
            // The execution-unit opcode only moves on entry to EXEC_START so it
            // stays put while the next request is being read.
            if (state_d == S_EXEC_START) begin
                exec_op_q <= (state_q == S_IDLE) ? req_opcode_i : opcode_q;
            end
        end
    end

    always_comb begin
        rd_en_o = '0;
        for (int i = 0; i < SRAM_R_PORT_CNT; i++) begin
            if ((state_q == S_READ) && (i < 32'(src_cnt_q))) begin
                rd_en_o[i] = 1'b1;
            end
        end
    end

    assign rd_addr_o     = src_addr_q;
    assign req_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign exec_start_o  = (state_q == S_EXEC_START);
    assign exec_opcode_o = exec_op_q;
    assign wr_en_o       = (state_q == S_WB);
    assign wr_addr_o     = dst_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_vpu_exec_sequencer.sv
// tb/tb_vpu_exec_sequencer.sv - scoreboard bench for vpu_exec_sequencer
module tb_vpu_exec_sequencer;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [7:0]  req_opcode_i = '0;
    logic [1:0]  req_src_cnt_i = '0;
    logic [29:0] req_src_addr_i = '0;
    logic [9:0]  req_dst_addr_i = '0;
    logic [2:0]  rd_en_o;
    logic [29:0] rd_addr_o;
    logic        exec_start_o;
    logic [7:0]  exec_opcode_o;
    logic        exec_done_i = 1'b0;
    logic        wr_en_o;
    logic [9:0]  wr_addr_o;
    logic        busy_o;
    logic        err_timeout_o;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  rd_q[$];
    ev_t  st_q[$];
    ev_t  wr_q[$];
    ev_t  er_q[$];
    ev_t  ev;

    vpu_exec_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_opcode_i   (req_opcode_i),
        .req_src_cnt_i  (req_src_cnt_i),
        .req_src_addr_i (req_src_addr_i),
        .req_dst_addr_i (req_dst_addr_i),
        .rd_en_o        (rd_en_o),
        .rd_addr_o      (rd_addr_o),
        .exec_start_o   (exec_start_o),
        .exec_opcode_o  (exec_opcode_o),
        .exec_done_i    (exec_done_i),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .busy_o         (busy_o),
        .err_timeout_o  (err_timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s act=event_at_cycle_%0d req=none", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rd_en_o != 3'b000) begin
            if (rd_q.size() == 0) unexpected("rd_unexpected");
            else begin
                ev = rd_q.pop_front();
                cmp("rd_cycle", 64'(cyc), 64'(ev.cyc));
                cmp("rd_data", 64'({rd_en_o, rd_addr_o}), ev.data);
            end
        end
        if (exec_start_o) begin
            if (st_q.size() == 0) unexpected("start_unexpected");
            else begin
                ev = st_q.pop_front();
                cmp("start_cycle", 64'(cyc), 64'(ev.cyc));
                cmp("start_opcode", 64'(exec_opcode_o), ev.data);
            end
        end
        if (wr_en_o) begin
            if (wr_q.size() == 0) unexpected("wr_unexpected");
            else begin
                ev = wr_q.pop_front();
                cmp("wr_cycle", 64'(cyc), 64'(ev.cyc));
                cmp("wr_addr", 64'(wr_addr_o), ev.data);
            end
        end
        if (err_timeout_o) begin
            if (er_q.size() == 0) unexpected("err_unexpected");
            else begin
                ev = er_q.pop_front();
                cmp("err_cycle", 64'(cyc), 64'(ev.cyc));
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Presents a request, waits for acceptance, and pushes the read and start
    // expectations. Returns at the negedge of the READ (or start) cycle.
    task automatic send(input logic [7:0] op, input logic [1:0] cnt,
                        input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                        input logic [9:0] dst, input logic [2:0] exp_mask,
                        input bit hold, output int t, output int s);
        int guard = 0;
        req_opcode_i   = op;
        req_src_cnt_i  = cnt;
        req_src_addr_i = {a2, a1, a0};
        req_dst_addr_i = dst;
        req_valid_i    = 1'b1;
        while (!req_ready_o && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) unexpected("accept_timeout");
        t = cyc;
        if (exp_mask != 3'b000) begin
            rd_q.push_back('{t + 1, 64'({exp_mask, a2, a1, a0})});
            s = t + 3;
        end else begin
            s = t + 1;
        end
        st_q.push_back('{s, 64'(op)});
        @(negedge clk);
        if (!hold) req_valid_i = 1'b0;
    endtask

    task automatic pulse_done_at(input int n);
        wait_cyc(n);
        exec_done_i = 1'b1;
        @(negedge clk);
        exec_done_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_ready"}, 64'(req_ready_o), 64'd1);
        cmp({tag, "_busy"}, 64'(busy_o), 64'd0);
        cmp({tag, "_rd_en"}, 64'(rd_en_o), 64'd0);
        cmp({tag, "_start"}, 64'(exec_start_o), 64'd0);
        cmp({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
        cmp({tag, "_err"}, 64'(err_timeout_o), 64'd0);
        cmp({tag, "_rd_addr"}, 64'(rd_addr_o), 64'd0);
        cmp({tag, "_wr_addr"}, 64'(wr_addr_o), 64'd0);
        cmp({tag, "_opcode"}, 64'(exec_opcode_o), 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog act=still_running req=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, s, t2, s2;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Three operands, done 3 cycles after start.
        send(8'hA5, 2'd3, 10'h010, 10'h020, 10'h030, 10'h040, 3'b111, 1'b0, t, s);
        wr_q.push_back('{t + 7, 64'h040});
        pulse_done_at(t + 6);
        cmp("a_ready_in_wb", 64'(req_ready_o), 64'd0);
        wait_cyc(t + 8);
        cmp("a_ready_back", 64'(req_ready_o), 64'd1);

        // One operand: only port 0 enabled, all address slices still presented.
        send(8'h3C, 2'd1, 10'h101, 10'h202, 10'h303, 10'h155, 3'b001, 1'b0, t, s);
        wr_q.push_back('{s + 3, 64'h155});
        pulse_done_at(s + 2);

        // No operands: start right after acceptance.
        send(8'h7E, 2'd0, 10'h000, 10'h000, 10'h000, 10'h2AA, 3'b000, 1'b0, t, s);
        wr_q.push_back('{t + 3, 64'h2AA});
        pulse_done_at(s + 1);

        // Timeout: EXEC_WAIT entered at s+1, pulse 255 cycles later.
        wait_cyc(cyc + 2);
        send(8'h55, 2'd2, 10'h001, 10'h002, 10'h003, 10'h3FF, 3'b011, 1'b0, t, s);
        er_q.push_back('{s + 256, 64'd0});
        wait_cyc(s + 255);
        cmp("to_busy_last_wait", 64'(busy_o), 64'd1);
        wait_cyc(s + 257);
        cmp("to_ready_after", 64'(req_ready_o), 64'd1);
        cmp("to_busy_after", 64'(busy_o), 64'd0);

        // Done coincident with start is ignored; the second one counts.
        send(8'h99, 2'd0, 10'h000, 10'h000, 10'h000, 10'h123, 3'b000, 1'b0, t, s);
        wr_q.push_back('{s + 3, 64'h123});
        pulse_done_at(s);
        pulse_done_at(s + 2);
        wait_cyc(s + 5);

        // Reset during EXEC_WAIT, then a stray done: nothing may come out.
        send(8'h44, 2'd2, 10'h005, 10'h006, 10'h007, 10'h0EE, 3'b011, 1'b0, t, s);
        wait_cyc(s + 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        exec_done_i = 1'b1;
        @(negedge clk);
        exec_done_i = 1'b0;
        wait_cyc(cyc + 6);
        send(8'h12, 2'd3, 10'h00A, 10'h00B, 10'h00C, 10'h00D, 3'b111, 1'b0, t, s);
        wr_q.push_back('{s + 2, 64'h00D});
        pulse_done_at(s + 1);
        wait_cyc(cyc + 2);

        // Back-to-back with req_valid_i held high.
        send(8'h11, 2'd1, 10'h021, 10'h022, 10'h023, 10'h031, 3'b001, 1'b1, t, s);
        req_opcode_i   = 8'h22;
        req_src_cnt_i  = 2'd2;
        req_src_addr_i = {10'h043, 10'h042, 10'h041};
        req_dst_addr_i = 10'h051;
        wr_q.push_back('{s + 2, 64'h031});
        pulse_done_at(s + 1);
        cmp("b2b_opcode_in_wb", 64'(exec_opcode_o), 64'h11);
        send(8'h22, 2'd2, 10'h041, 10'h042, 10'h043, 10'h051, 3'b011, 1'b0, t2, s2);
        cmp("b2b_accept_cycle", 64'(t2), 64'(s + 3));
        wait_cyc(t2 + 2);
        cmp("b2b_opcode_rd_wait", 64'(exec_opcode_o), 64'h11);
        wr_q.push_back('{t2 + 5, 64'h051});
        pulse_done_at(t2 + 4);

        wait_cyc(cyc + 10);
        cmp("rd_left", 64'(rd_q.size()), 64'd0);
        cmp("start_left", 64'(st_q.size()), 64'd0);
        cmp("wr_left", 64'(wr_q.size()), 64'd0);
        cmp("err_left", 64'(er_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vpu_exec_sequencer.md
VPU_EXEC_SEQUENCER -- requirements
Module: vpu_exec_sequencer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- SRAM_R_PORT_CNT, 3: source operand read ports.
- ADDR_WIDTH, 10: SRAM address width.
- OPCODE_WIDTH, 8: opcode width.
- RD_LATENCY, 2: cycles from the rd_en_o cycle to valid rdata; legal range 1..8.
- TIMEOUT, 255: maximum cycles waited for exec_done_i.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: the only clock.
- rst, in, 1: reset, synchronous and active-high.
- req_valid_i, in, 1: decoded request valid.
- req_ready_o, out, 1: sequencer accepts a request.
- req_opcode_i, in, OPCODE_WIDTH: operation code.
- req_src_cnt_i, in, 2: number of source operands, 0..3.
- req_src_addr_i, in, SRAM_R_PORT_CNT*ADDR_WIDTH: source addresses; port i occupies slice i.
- req_dst_addr_i, in, ADDR_WIDTH: writeback address.
- rd_en_o, out, SRAM_R_PORT_CNT: per-port read enable.
- rd_addr_o, out, SRAM_R_PORT_CNT*ADDR_WIDTH: per-port read address.
- exec_start_o, out, 1: one-cycle start pulse to the execution unit.
- exec_opcode_o, out, OPCODE_WIDTH: latched opcode, held stable from start until done.
- exec_done_i, in, 1: execution unit completion pulse.
- wr_en_o, out, 1: result writeback strobe.
- wr_addr_o, out, ADDR_WIDTH: writeback address.
- busy_o, out, 1: high when the state is not IDLE.
- err_timeout_o, out, 1: one-cycle pulse when the execution unit times out.

Function
REQ-003 The FSM SHALL have the states IDLE, READ, RD_WAIT, EXEC_START, EXEC_WAIT and WB; every output SHALL be decoded from registered state (Moore outputs).
REQ-004 The block SHALL drive req_ready_o=1 only in IDLE; a request SHALL be accepted when req_valid_i&&req_ready_o, at which point the opcode, source count, source addresses and destination address SHALL be latched.
REQ-005 On acceptance, the FSM SHALL go to READ if src_cnt>0 and to EXEC_START if src_cnt==0.
REQ-006 The latched src_cnt SHALL be clamped to SRAM_R_PORT_CNT when the input exceeds it.
REQ-007 READ SHALL last exactly 1 cycle with rd_en_o[i]=1 for i<src_cnt, 0 otherwise, and rd_addr_o equal to the latched addresses; rd_addr_o SHALL hold its last value outside READ.
REQ-008 RD_WAIT SHALL last RD_LATENCY-1 cycles, counted by a down-counter; for RD_LATENCY==1 the FSM SHALL go from READ directly to EXEC_START.
REQ-009 EXEC_START SHALL last 1 cycle with exec_start_o=1, so that the start pulse falls exactly RD_LATENCY cycles after the READ cycle.
REQ-010 In EXEC_WAIT, exec_done_i SHALL be sampled; done=1 SHALL move the FSM to WB.
REQ-011 exec_done_i SHALL be ignored in every state other than EXEC_WAIT, including EXEC_START.
REQ-012 EXEC_WAIT SHALL count cycles; if TIMEOUT cycles elapse without done, the FSM SHALL return to IDLE, pulse err_timeout_o for 1 cycle and perform no writeback.
REQ-013 When done arrives in the same cycle the count reaches TIMEOUT, done SHALL win and no error SHALL be raised.
REQ-014 WB SHALL last 1 cycle with wr_en_o=1 and wr_addr_o equal to the latched destination, then the FSM SHALL return to IDLE.
REQ-015 Latency: a request accepted at cycle T SHALL produce READ at T+1 and exec_start_o at T+1+RD_LATENCY; for src_cnt==0, exec_start_o SHALL be at T+1.
REQ-016 For done at cycle D, wr_en_o SHALL be at D+1 and req_ready_o SHALL return at D+2.
REQ-017 No request SHALL be accepted while busy; req_valid_i held high during busy SHALL be accepted on the first IDLE cycle.
REQ-018 exec_opcode_o SHALL remain stable from EXEC_START through EXEC_WAIT.

Reset
REQ-019 When rst=1 at a clock edge, the state SHALL become IDLE and all counters SHALL clear; rd_en_o=0, exec_start_o=0, wr_en_o=0, err_timeout_o=0, busy_o=0, req_ready_o=1 and all address and opcode outputs=0 from the next cycle.
REQ-020 A reset applied in any state, including EXEC_WAIT or WB, SHALL abort the operation; no wr_en_o or err_timeout_o SHALL be emitted afterwards.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Src_cnt=3, addrs 0x010/0x020/0x030, dst 0x040, RD_LATENCY=2, done 3 cycles after start -> rd_en_o=3'b111 at T+1, exec_start_o at T+3, wr_en_o with wr_addr_o=0x040 at T+7, req_ready_o at T+8.
- Src_cnt=1 -> rd_en_o=3'b001 only; src_cnt=0 -> no rd_en_o and exec_start_o at T+1.
- Done never asserted, TIMEOUT=255 -> err_timeout_o pulses once, 255 cycles after entering EXEC_WAIT; no wr_en_o; req_ready_o=1 next cycle.
- Done asserted coincident with exec_start_o and then again 2 cycles later -> only the second done counts; exactly one wr_en_o.
- Rst=1 during EXEC_WAIT, then done pulsed -> no wr_en_o; outputs at reset values; a new request is accepted normally.
- Back-to-back requests with req_valid_i held high -> second request accepted on the cycle after WB; exec_opcode_o changes only at the second EXEC_START.
